line_fill_unit: RTL and testbench

Line-fill adapter between the instruction cache's memory port and the word-wide main memory. On a cache refill request it fetches the aligned line as NrWords consecutive 32-bit reads over a request/grant/rvalid word bus. It assembles the words into one LineSize-bit line, word 0 in the least-significant bits, and returns it with a one-cycle valid pulse. Requests the cache withdraws or retargets mid-fill are aborted cleanly, without a stale response.

---
 rtl/line_fill_unit_if.sv | 25 ++
 rtl/line_fill_unit.sv | 102 ++++++++++
 tb/tb_line_fill_unit.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_unit_if.sv
// Bundles the cache refill port and the word-wide memory bus of the line fill unit.
// The master side is the fill unit; the slave side is the cache and memory environment.
interface line_fill_unit_if #(
    parameter int LineSize = 128
);
    logic [31:0]         mem_addr_i;
    logic                mem_read_en_i;
    logic                mem_read_valid_o;
    logic [LineSize-1:0] mem_read_data_o;
    logic                word_req_o;
    logic [31:0]         word_addr_o;
    logic                word_gnt_i;
    logic                word_rvalid_i;
    logic [31:0]         word_rdata_i;

    modport master (
        input  mem_addr_i, mem_read_en_i, word_gnt_i, word_rvalid_i, word_rdata_i,
        output mem_read_valid_o, mem_read_data_o, word_req_o, word_addr_o
    );

    modport slave (
        output mem_addr_i, mem_read_en_i, word_gnt_i, word_rvalid_i, word_rdata_i,
        input  mem_read_valid_o, mem_read_data_o, word_req_o, word_addr_o
    );
endinterface

// File: rtl/line_fill_unit.sv
// Refills one cache line as NrWords sequential 32-bit reads, at most one in flight,
// and returns the assembled line with a one-cycle valid pulse. Withdrawn or retargeted
// requests abort after draining any granted beat.
module line_fill_unit #(
    parameter  int ByteOffsetBits = 4,
    localparam int NrWords        = (2**ByteOffsetBits) / 4,
    localparam int LineSize       = 32 * NrWords,
    localparam int BeatW          = (NrWords > 1) ? $clog2(NrWords) : 1
) (
    input logic              clk_i,
    input logic              rstn_i,
    line_fill_unit_if.master bus
);
    localparam logic [31:0] OffMask = 32'((64'd1 << ByteOffsetBits) - 64'd1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [31:0]             r_base;
    logic [BeatW-1:0]        r_beat;
    logic                    r_abort;
    logic [NrWords-1:0][31:0] r_data;

    logic w_start;
    logic w_beat_inc;
    logic w_data_we;
    logic w_abort_now;
    logic w_abort;
    logic w_last;

    assign w_abort_now = !bus.mem_read_en_i || ((bus.mem_addr_i & ~OffMask) != r_base);
    assign w_abort     = r_abort || w_abort_now;
    assign w_last      = (r_beat == BeatW'(NrWords - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // A granted beat is never abandoned: WAIT_DATA only leaves on rvalid, even when aborted.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_beat_inc  = 1'b0;
        w_data_we   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_read_en_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.word_gnt_i) w_state_nxt = WAIT_DATA;
                else if (w_abort)   w_state_nxt = IDLE;
            end
            WAIT_DATA: begin
                if (bus.word_rvalid_i) begin
                    w_data_we = 1'b1;
                    if (w_abort)     w_state_nxt = IDLE;
                    else if (w_last) w_state_nxt = DONE;
                    else begin
                        w_beat_inc  = 1'b1;
                        w_state_nxt = REQ;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_base  <= '0;
            r_beat  <= '0;
            r_abort <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_start) begin
                r_base  <= bus.mem_addr_i & ~OffMask;
                r_beat  <= '0;
                r_abort <= 1'b0;
            end else if (r_state == REQ || r_state == WAIT_DATA) begin
                r_abort <= w_abort;
            end
            if (w_beat_inc) r_beat <= r_beat + 1'b1;
            if (w_data_we)  r_data[r_beat] <= bus.word_rdata_i;
        end
    end

    assign bus.word_req_o       = (r_state == REQ);
    assign bus.word_addr_o      = (r_state == REQ) ? (r_base + (32'(r_beat) << 2)) : '0;
    assign bus.mem_read_valid_o = (r_state == DONE);
    assign bus.mem_read_data_o  = r_data;
endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: a word memory model with per-beat grant/latency,
// a scoreboard of expected lines, and one task per scenario.
module tb_line_fill_unit;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    line_fill_unit_if #(.LineSize(128)) bus ();
    line_fill_unit #(.ByteOffsetBits(4)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory model configuration and logs
    int          g_wait [4];
    int          l_lat  [4];
    int          gcnt = 0;
    int          pend = 0;
    logic [31:0] pend_data;
    logic [31:0] hold_addr;
    bit          hold_v = 0;
    int          unstable_cnt = 0;
    int          overlap_cnt  = 0;
    int          gl_cyc [$];
    logic [31:0] gl_addr[$];

    // valid monitor logs
    int           v_cyc [$];
    logic [127:0] v_data[$];
    bit           prev_v = 0;
    int           wide_pulse_cnt = 0;

    logic [127:0] sb[$];

    function automatic logic [31:0] mword(input logic [31:0] a);
        if (a[31:4] == 28'h0000010) begin
            case (a[3:2])
                2'd0:    return 32'h11111111;
                2'd1:    return 32'h22222222;
                2'd2:    return 32'h33333333;
                default: return 32'h44444444;
            endcase
        end
        return a ^ 32'hA5C3_0000;
    endfunction

    function automatic logic [127:0] mline(input logic [31:0] b);
        return {mword(b + 32'd12), mword(b + 32'd8), mword(b + 32'd4), mword(b)};
    endfunction

    always @(negedge clk) begin
        bus.word_gnt_i    = 1'b0;
        bus.word_rvalid_i = 1'b0;
        if (!rstn) begin
            pend   = 0;
            gcnt   = 0;
            hold_v = 0;
        end else begin
            if (pend > 0) begin
                pend = pend - 1;
                if (pend == 0) begin
                    bus.word_rvalid_i = 1'b1;
                    bus.word_rdata_i  = pend_data;
                end
            end
            if (bus.word_req_o) begin
                if (hold_v && bus.word_addr_o !== hold_addr) unstable_cnt++;
                if (pend != 0) overlap_cnt++;
                if (gcnt < g_wait[bus.word_addr_o[3:2]]) begin
                    gcnt++;
                    hold_v    = 1;
                    hold_addr = bus.word_addr_o;
                end else begin
                    bus.word_gnt_i = 1'b1;
                    gcnt      = 0;
                    hold_v    = 0;
                    pend      = l_lat[bus.word_addr_o[3:2]];
                    pend_data = mword(bus.word_addr_o);
                    gl_cyc.push_back(cyc);
                    gl_addr.push_back(bus.word_addr_o);
                end
            end else begin
                gcnt   = 0;
                hold_v = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && bus.mem_read_valid_o) begin
            if (prev_v) wide_pulse_cnt++;
            v_cyc.push_back(cyc);
            v_data.push_back(bus.mem_read_data_o);
        end
        prev_v = rstn && bus.mem_read_valid_o;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mem(input int g1, input int l);
        for (int k = 0; k < 4; k++) begin
            g_wait[k] = 0;
            l_lat[k]  = l;
        end
        g_wait[1] = g1;
    endtask

    // pop each new valid against the scoreboard, check count and timing of the fill's pulses
    task automatic check_valids(input string name, input int v0, input int nexp, input int t0,
                                input int c0, input int c1);
        int n;
        n = v_cyc.size() - v0;
        tests++;
        if (n !== nexp) begin
            fails++;
            $display("FAIL %s valid_count got=%0d exp=%0d", name, n, nexp);
        end
        for (int k = 0; k < n; k++) begin
            logic [127:0] e;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL %s unexpected_valid at rel cycle %0d", name, v_cyc[v0+k] - t0);
                continue;
            end
            e = sb.pop_front();
            if (v_data[v0+k] !== e) begin
                fails++;
                $display("FAIL %s line%0d got=%h exp=%h", name, k, v_data[v0+k], e);
            end
            if (k < 2) begin
                tests++;
                if (v_cyc[v0+k] - t0 !== ((k == 0) ? c0 : c1)) begin
                    fails++;
                    $display("FAIL %s valid%0d_cycle got=%0d exp=%0d", name, k, v_cyc[v0+k] - t0,
                             (k == 0) ? c0 : c1);
                end
            end
        end
        tests++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL %s scoreboard_left got=%0d exp=0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_grants(input string name, input int g0, input int t0,
                                input logic [31:0] ea[], input int ec[]);
        tests++;
        if (gl_addr.size() - g0 !== ea.size()) begin
            fails++;
            $display("FAIL %s grant_count got=%0d exp=%0d", name, gl_addr.size() - g0, ea.size());
        end else begin
            for (int k = 0; k < ea.size(); k++) begin
                tests++;
                if (gl_addr[g0+k] !== ea[k]) begin
                    fails++;
                    $display("FAIL %s addr%0d got=%h exp=%h", name, k, gl_addr[g0+k], ea[k]);
                end
                if (k < ec.size()) begin
                    tests++;
                    if (gl_cyc[g0+k] - t0 !== ec[k]) begin
                        fails++;
                        $display("FAIL %s gnt%0d_cycle got=%0d exp=%0d", name, k, gl_cyc[g0+k] - t0, ec[k]);
                    end
                end
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        tests++;
        if (bus.word_req_o !== 1'b0 || bus.word_addr_o !== 32'h0 ||
            bus.mem_read_valid_o !== 1'b0 || bus.mem_read_data_o !== 128'h0) begin
            fails++;
            $display("FAIL %s outputs req=%b addr=%h valid=%b data=%h exp all zero", name,
                     bus.word_req_o, bus.word_addr_o, bus.mem_read_valid_o, bus.mem_read_data_o);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.mem_read_en_i = 1'b0;
        bus.mem_addr_i    = 32'h0;
        set_mem(0, 1);
        step(2);
        check_outputs_zero("reset");
        rstn = 1'b1;
        step(2);
        tests++;
        if (bus.word_req_o !== 1'b0) begin
            fails++;
            $display("FAIL reset idle_req got=%b exp=0", bus.word_req_o);
        end
    endtask

    task automatic test_basic();
        int t0, v0, g0;
        v0 = v_cyc.size(); g0 = gl_addr.size();
        set_mem(0, 1);
        bus.mem_addr_i = 32'h0000_0104; bus.mem_read_en_i = 1'b1; t0 = cyc;
        sb.push_back(128'h44444444_33333333_22222222_11111111);
        step(10);
        bus.mem_read_en_i = 1'b0;
        step(4);
        check_grants("basic", g0, t0, '{32'h100, 32'h104, 32'h108, 32'h10C}, '{1, 3, 5, 7});
        check_valids("basic", v0, 1, t0, 9, 0);
    endtask

    task automatic test_wait_states();
        int t0, v0, g0, u0;
        v0 = v_cyc.size(); g0 = gl_addr.size(); u0 = unstable_cnt;
        set_mem(2, 3);
        bus.mem_addr_i = 32'h0000_0120; bus.mem_read_en_i = 1'b1; t0 = cyc;
        sb.push_back(mline(32'h120));
        step(20);
        bus.mem_read_en_i = 1'b0;
        step(4);
        set_mem(0, 1);
        check_grants("wait", g0, t0, '{32'h120, 32'h124, 32'h128, 32'h12C}, '{1, 7, 11, 15});
        check_valids("wait", v0, 1, t0, 19, 0);
        tests++;
        if (unstable_cnt !== u0) begin
            fails++;
            $display("FAIL wait addr_unstable got=%0d exp=%0d", unstable_cnt, u0);
        end
    endtask

    task automatic test_withdraw();
        int t0, v0, g0;
        v0 = v_cyc.size(); g0 = gl_addr.size();
        set_mem(0, 1);
        bus.mem_addr_i = 32'h0000_0140; bus.mem_read_en_i = 1'b1; t0 = cyc;
        step(4);
        bus.mem_read_en_i = 1'b0;
        step(2);
        tests++;
        if (bus.word_req_o !== 1'b0) begin
            fails++;
            $display("FAIL withdraw req_at_cycle6 got=%b exp=0", bus.word_req_o);
        end
        step(6);
        check_grants("withdraw", g0, t0, '{32'h140, 32'h144}, '{1, 3});
        check_valids("withdraw", v0, 0, t0, 0, 0);
    endtask

    task automatic test_retarget();
        int t0, v0, g0;
        v0 = v_cyc.size(); g0 = gl_addr.size();
        set_mem(0, 1);
        bus.mem_addr_i = 32'h0000_0100; bus.mem_read_en_i = 1'b1; t0 = cyc;
        sb.push_back(mline(32'h200));
        step(6);
        bus.mem_addr_i = 32'h0000_0200;
        step(11);
        bus.mem_read_en_i = 1'b0;
        step(4);
        check_grants("retarget", g0, t0,
                     '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204, 32'h208, 32'h20C},
                     '{1, 3, 5, 8, 10, 12, 14});
        check_valids("retarget", v0, 1, t0, 16, 0);
    endtask

    task automatic test_reset_mid();
        int t0, v0, g0;
        set_mem(0, 1);
        bus.mem_addr_i = 32'h0000_0100; bus.mem_read_en_i = 1'b1;
        step(5);
        rstn = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        step(1);
        v0 = v_cyc.size(); g0 = gl_addr.size();
        bus.mem_addr_i = 32'h0000_0040;
        rstn = 1'b1; t0 = cyc;
        sb.push_back(mline(32'h40));
        step(10);
        bus.mem_read_en_i = 1'b0;
        step(4);
        check_grants("reset_mid", g0, t0, '{32'h40, 32'h44, 32'h48, 32'h4C}, '{1, 3, 5, 7});
        check_valids("reset_mid", v0, 1, t0, 9, 0);
    endtask

    task automatic test_back_to_back();
        int t0, v0, g0;
        v0 = v_cyc.size(); g0 = gl_addr.size();
        set_mem(0, 1);
        bus.mem_addr_i = 32'h0000_0100; bus.mem_read_en_i = 1'b1; t0 = cyc;
        sb.push_back(128'h44444444_33333333_22222222_11111111);
        step(10);
        bus.mem_addr_i = 32'h0000_0300;
        sb.push_back(mline(32'h300));
        step(10);
        bus.mem_read_en_i = 1'b0;
        step(4);
        check_grants("b2b", g0, t0,
                     '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h300, 32'h304, 32'h308, 32'h30C},
                     '{1, 3, 5, 7, 11, 13, 15, 17});
        check_valids("b2b", v0, 2, t0, 9, 19);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_withdraw();
        test_retarget();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (overlap_cnt !== 0 || wide_pulse_cnt !== 0) begin
            fails++;
            $display("FAIL protocol overlap=%0d wide_valid=%0d exp 0/0", overlap_cnt, wide_pulse_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
